button_debounce_multi: RTL and testbench
========================================

// Module: button_debounce_multi
// PURPOSE
//  Parametrised N-channel push-button conditioner; successor to the single-button debouncer.
//  Per channel: 2-FF synchroniser, counter-based debounce window, press/release pulses,
//  long-press detection and optional auto-repeat. Sits between board buttons and the counter control FSM.
// PARAMETERS
//  N_CH          4      number of button channels
//  DEBOUNCE_CYC  50000  consecutive differing clk_core cycles required to accept a level change (>=1)
//  LONG_CYC      1000   cycles of accepted-high level before long_o fires (>=1)
//  REPEAT_CYC    250    auto-repeat period after long press (>=1)
//  REPEAT_EN     1      1: generate repeat_o pulses; 0: repeat_o tied 0
//  ACTIVE_HIGH   1      1: pressed = input 1; 0: input inverted after synchroniser
// PORTS
//  clk_core     in   1     core clock, all logic on rising edge
//  rst_n        in   1     asynchronous active-low reset
//  button_i     in   N_CH  raw asynchronous button inputs
//  level_o      out  N_CH  debounced pressed level
//  press_o      out  N_CH  1-cycle pulse on accepted press
//  release_o    out  N_CH  1-cycle pulse on accepted release
//  long_o       out  N_CH  1-cycle pulse once per press after LONG_CYC held
//  repeat_o     out  N_CH  1-cycle auto-repeat pulses after long_o
//  any_press_o  out  1     OR of press_o
// BEHAVIOUR
//  - Reset: sync flops, counters, level_o and all pulse outputs = 0 (idle = released).
//  - Sync: s = 2-FF sync of button_i[k], inverted when ACTIVE_HIGH=0.
//  - Debounce: s == level -> deb_cnt <= 0. s != level -> deb_cnt++; on the cycle deb_cnt == DEBOUNCE_CYC-1
//    with s still != level: level <= s, deb_cnt <= 0. A single agreeing sample restarts the window.
//  - Latency: stable edge on button_i -> level_o change after 2 + DEBOUNCE_CYC clocks.
//  - press_o/release_o registered, high exactly in the first cycle level_o shows the new value.
//  - Hold counter: cleared while level=0 and on the press cycle; increments while level=1; saturates.
//    long_o pulses in the cycle hold_cnt reaches LONG_CYC (i.e. LONG_CYC cycles after press_o); once per press.
//  - Repeat (REPEAT_EN=1): after long_o, rep_cnt counts; repeat_o pulses every REPEAT_CYC cycles
//    (first at long_o + REPEAT_CYC) while level=1. Release stops it immediately; no pulse in release cycle.
//  - Channels fully independent; simultaneous events on several channels all reported same cycle.
//  - Glitch shorter than DEBOUNCE_CYC cycles: no level, press or release change.
//  - Release on the same cycle long_o/repeat_o would fire: release_o only; long/repeat suppressed.
//  - Reset mid-press: outputs drop to 0 asynchronously; button still held after reset -> fresh press_o
//    after 2 + DEBOUNCE_CYC cycles, long/repeat timing restarts.
//  - Widths: deb_cnt $clog2(DEBOUNCE_CYC+1), hold_cnt $clog2(LONG_CYC+1), rep_cnt $clog2(REPEAT_CYC+1);
//    no counter wraps.
// STRUCTURE
//  - Shared header btn_defs.vh: default timing constants (DEBOUNCE_CYC/LONG_CYC/REPEAT_CYC for 50 MHz board),
//    polarity constant.
//  - Sub-module button_debounce_ch: one channel (sync, debounce, hold/repeat counters, 5 outputs);
//    top instantiates N_CH copies in a generate loop and ORs press_o into any_press_o.
//  - Parameter sanity checks (>=1) in an initial block, simulation only.
// TESTING  (N_CH=2, DEBOUNCE_CYC=4, LONG_CYC=20, REPEAT_CYC=8, REPEAT_EN=1, ACTIVE_HIGH=1)
//  1. rst_n low with button_i=2'b11 -> all outputs 0; release rst_n, hold -> press_o=2'b11, level_o=2'b11
//     exactly 6 cycles later.
//  2. ch0 glitch high for 3 cycles, twice with 1-cycle low gap -> level_o[0], press_o[0] never assert.
//  3. ch0 held 60 cycles after press_o -> long_o at +20, repeat_o at +28,+36,+44,+52,+60 only while held.
//  4. ch0 release 10 cycles after press -> release_o[0] 1 cycle at +6 after release; no long_o.
//  5. ch0 and ch1 pressed same cycle, ch1 released at hold=19 -> ch0 gets long_o; ch1 release_o only.
//  6. assert rst_n low mid-repeat on ch0 -> outputs 0 immediately; after release a new press_o at +6,
//     long_o 20 cycles after it.

Source files
------------

// File: rtl/button_debounce_multi_pkg.sv
// Shared constants for the multi-channel button conditioner.
// Defaults are the 50 MHz board timings and the board's button polarity.
package button_debounce_multi_pkg;

  localparam int DEF_N_CH         = 4;
  localparam int DEF_DEBOUNCE_CYC = 50000;
  localparam int DEF_LONG_CYC     = 1000;
  localparam int DEF_REPEAT_CYC   = 250;
  localparam bit DEF_REPEAT_EN    = 1'b1;
  localparam bit DEF_ACTIVE_HIGH  = 1'b1;

  // Width of a counter that must hold values 0..max_val without wrapping.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/button_debounce_multi_ch.sv
// One button channel: synchroniser, debounce window, press/release pulses,
// long-press detection and optional auto-repeat.
module button_debounce_multi_ch
  import button_debounce_multi_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int LONG_CYC     = DEF_LONG_CYC,
  parameter int REPEAT_CYC   = DEF_REPEAT_CYC,
  parameter bit REPEAT_EN    = DEF_REPEAT_EN,
  parameter bit ACTIVE_HIGH  = DEF_ACTIVE_HIGH
) (
  input  logic clk_core,
  input  logic rst_n,
  input  logic button_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o
);

  localparam int DW = cnt_width(DEBOUNCE_CYC);
  localparam int HW = cnt_width(LONG_CYC);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYC);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYC - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic          sample;
  logic          accept;
  logic [DW-1:0] deb_cnt;
  logic [HW-1:0] hold_cnt;

  // Two-flop synchroniser for the asynchronous board input.
  always_ff @(posedge clk_core or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= button_i;
      sync_q2 <= sync_q1;
    end
  end

  // Polarity is normalised here so everything downstream treats 1 as pressed.
  assign sample = ACTIVE_HIGH ? sync_q2 : ~sync_q2;
  assign accept = (sample != level_o) && (deb_cnt == DEB_LAST);

  // Debounce window: any agreeing sample restarts the count of differing samples.
  always_ff @(posedge clk_core or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt <= '0;
      level_o <= 1'b0;
    end else if (sample == level_o) begin
      deb_cnt <= '0;
    end else if (accept) begin
      deb_cnt <= '0;
      level_o <= sample;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  // Edge pulses line up with the first cycle the new level is visible.
  always_ff @(posedge clk_core or negedge rst_n) begin
    if (!rst_n) begin
      press_o   <= 1'b0;
      release_o <= 1'b0;
    end else begin
      press_o   <= accept & sample;
      release_o <= accept & ~sample;
    end
  end

  // Hold counter saturates at LONG_CYC; a release edge clears it so long_o cannot collide with release_o.
  always_ff @(posedge clk_core or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      long_o   <= 1'b0;
    end else begin
      long_o <= 1'b0;
      if (!level_o || accept) begin
        hold_cnt <= '0;
      end else if (hold_cnt != HOLD_MAX) begin
        hold_cnt <= hold_cnt + 1'b1;
        long_o   <= (hold_cnt == HOLD_LAST);
      end
    end
  end

  if (REPEAT_EN) begin : g_repeat
    localparam int RW = cnt_width(REPEAT_CYC);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYC - 1);

    logic [RW-1:0] rep_cnt;

    // Repeat phase runs only once the hold counter has saturated, and stops on the release edge.
    always_ff @(posedge clk_core or negedge rst_n) begin
      if (!rst_n) begin
        rep_cnt  <= '0;
        repeat_o <= 1'b0;
      end else begin
        repeat_o <= 1'b0;
        if (!level_o || accept || (hold_cnt != HOLD_MAX)) begin
          rep_cnt <= '0;
        end else if (rep_cnt == REP_LAST) begin
          rep_cnt  <= '0;
          repeat_o <= 1'b1;
        end else begin
          rep_cnt <= rep_cnt + 1'b1;
        end
      end
    end
  end else begin : g_no_repeat
    assign repeat_o = 1'b0;
  end

endmodule

// File: rtl/button_debounce_multi.sv
// N-channel push-button conditioner feeding the counter control FSM.
// Each channel is independent; any_press_o flags a press on any channel.
module button_debounce_multi
  import button_debounce_multi_pkg::*;
#(
  parameter int N_CH         = DEF_N_CH,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int LONG_CYC     = DEF_LONG_CYC,
  parameter int REPEAT_CYC   = DEF_REPEAT_CYC,
  parameter bit REPEAT_EN    = DEF_REPEAT_EN,
  parameter bit ACTIVE_HIGH  = DEF_ACTIVE_HIGH
) (
  input  logic            clk_core,
  input  logic            rst_n,
  input  logic [N_CH-1:0] button_i,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] press_o,
  output logic [N_CH-1:0] release_o,
  output logic [N_CH-1:0] long_o,
  output logic [N_CH-1:0] repeat_o,
  output logic            any_press_o
);

  // Timing parameters below 1 would make the counters meaningless.
  if (N_CH < 1 || DEBOUNCE_CYC < 1 || LONG_CYC < 1 || REPEAT_CYC < 1) begin : g_param_err
    $error("button_debounce_multi: N_CH and all *_CYC parameters must be >= 1");
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    button_debounce_multi_ch #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .LONG_CYC    (LONG_CYC),
      .REPEAT_CYC  (REPEAT_CYC),
      .REPEAT_EN   (REPEAT_EN),
      .ACTIVE_HIGH (ACTIVE_HIGH)
    ) u_ch (
      .clk_core (clk_core),
      .rst_n    (rst_n),
      .button_i (button_i[k]),
      .level_o  (level_o[k]),
      .press_o  (press_o[k]),
      .release_o(release_o[k]),
      .long_o   (long_o[k]),
      .repeat_o (repeat_o[k])
    );
  end

  assign any_press_o = |press_o;

endmodule

// File: tb/tb_button_debounce_multi.sv
// Directed bench for button_debounce_multi with short timing constants.
// Each scenario is a table of cycle-stamped records; cycles not listed expect
// no pulses and the most recently listed level.
module tb_button_debounce_multi;

  localparam int N_CH         = 2;
  localparam int DEBOUNCE_CYC = 4;
  localparam int LONG_CYC     = 20;
  localparam int REPEAT_CYC   = 8;

  logic            clk_core = 1'b0;
  logic            rst_n;
  logic [N_CH-1:0] button_i;
  logic [N_CH-1:0] level_o;
  logic [N_CH-1:0] press_o;
  logic [N_CH-1:0] release_o;
  logic [N_CH-1:0] long_o;
  logic [N_CH-1:0] repeat_o;
  logic            any_press_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         cyc;
    bit         drive;
    logic [1:0] btn;
    logic [1:0] lvl;
    logic [1:0] prs;
    logic [1:0] rel;
    logic [1:0] lng;
    logic [1:0] rpt;
  } vec_t;

  vec_t vecs[$];

  button_debounce_multi #(
    .N_CH        (N_CH),
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .LONG_CYC    (LONG_CYC),
    .REPEAT_CYC  (REPEAT_CYC),
    .REPEAT_EN   (1'b1),
    .ACTIVE_HIGH (1'b1)
  ) dut (
    .clk_core   (clk_core),
    .rst_n      (rst_n),
    .button_i   (button_i),
    .level_o    (level_o),
    .press_o    (press_o),
    .release_o  (release_o),
    .long_o     (long_o),
    .repeat_o   (repeat_o),
    .any_press_o(any_press_o)
  );

  // Free-running core clock.
  always #5 clk_core = ~clk_core;

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [1:0] btn);
    button_i = btn;
  endtask

  task automatic checkOutput(input string name, input logic [10:0] exp_v);
    logic [10:0] act;
    act = {level_o, press_o, release_o, long_o, repeat_o, any_press_o};
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("[TB] FAIL %s: got lvl/prs/rel/lng/rpt/any=%b want %b", name, act, exp_v);
    end
  endtask

  task automatic addVec(input int cyc, input bit drive, input logic [1:0] btn,
                        input logic [1:0] lvl, input logic [1:0] prs, input logic [1:0] rel,
                        input logic [1:0] lng, input logic [1:0] rpt);
    vec_t v;
    v.cyc = cyc; v.drive = drive; v.btn = btn;
    v.lvl = lvl; v.prs = prs; v.rel = rel; v.lng = lng; v.rpt = rpt;
    vecs.push_back(v);
  endtask

  // Cycle c is observed 1 time unit after the (c+1)-th rising edge of the segment;
  // inputs driven in cycle c are first sampled on the next edge.
  task automatic runSeg(input string tag, input int len, input logic [1:0] start_lvl);
    logic [1:0]  cur_lvl;
    logic [1:0]  prs, rel, lng, rpt;
    logic [10:0] exp_v;
    int          idx;
    cur_lvl = start_lvl;
    idx     = 0;
    for (int c = 0; c < len; c++) begin
      @(posedge clk_core);
      #1;
      prs = 2'b00; rel = 2'b00; lng = 2'b00; rpt = 2'b00;
      if (idx < vecs.size() && vecs[idx].cyc == c) begin
        cur_lvl = vecs[idx].lvl;
        prs = vecs[idx].prs; rel = vecs[idx].rel;
        lng = vecs[idx].lng; rpt = vecs[idx].rpt;
      end
      exp_v = {cur_lvl, prs, rel, lng, rpt, |prs};
      checkOutput($sformatf("%s c%0d", tag, c), exp_v);
      if (idx < vecs.size() && vecs[idx].cyc == c) begin
        if (vecs[idx].drive) applyStimulus(vecs[idx].btn);
        idx++;
      end
    end
    vecs.delete();
  endtask

  initial begin
    // Test 1: reset with both buttons held, then press seen 6 edges after release of reset.
    rst_n = 1'b0;
    applyStimulus(2'b11);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_core);
      #1;
      checkOutput($sformatf("t1 in reset %0d", i), 11'd0);
    end
    rst_n = 1'b1;
    addVec( 5, 1'b0, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00);
    addVec( 9, 1'b1, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
    addVec(15, 1'b0, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00);
    runSeg("t1", 20, 2'b00);

    // Test 2: two 3-cycle glitches on ch0 separated by a 1-cycle gap are rejected.
    addVec( 0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    addVec( 3, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    addVec( 4, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    addVec( 7, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    runSeg("t2", 20, 2'b00);

    // Test 3: long hold on ch0, long_o at press+20, repeats every 8 until release.
    addVec( 0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    addVec( 6, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
    addVec(26, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00);
    addVec(34, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
    addVec(42, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
    addVec(50, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
    addVec(58, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
    addVec(66, 1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
    addVec(72, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
    runSeg("t3", 80, 2'b00);

    // Test 4: short press on ch0, release 10 cycles after press, no long_o.
    addVec( 0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    addVec( 6, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
    addVec(16, 1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    addVec(22, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
    runSeg("t4", 35, 2'b00);

    // Test 5: both pressed together; ch1 released on the cycle its long_o would fire.
    addVec( 0, 1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    addVec( 6, 1'b0, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00);
    addVec(20, 1'b1, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
    addVec(26, 1'b0, 2'b00, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00);
    addVec(34, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
    addVec(35, 1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    addVec(41, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
    runSeg("t5", 50, 2'b00);

    // Test 6: reset in the repeat phase, then a fresh press with restarted timing.
    addVec( 0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    addVec( 6, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
    addVec(26, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00);
    addVec(34, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
    runSeg("t6 pre", 36, 2'b00);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6 async reset", 11'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk_core);
      #1;
      checkOutput($sformatf("t6 in reset %0d", i), 11'd0);
    end
    rst_n = 1'b1;
    addVec( 5, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
    addVec(25, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00);
    addVec(33, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
    addVec(34, 1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    addVec(40, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
    runSeg("t6 post", 44, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
